// File: rtl/monty_pkg.sv
// Shared definitions for the word-serial multiplier that feeds the
// word-level Montgomery reducer.
//   wsmul_state_t : control states of the multiplier
//   wsmul_nd      : number of B digits (cycles in BUSY) for LOGQ/DW
//   wsmul_lat     : accept-to-result latency, composable with the reducer
//   wsmul_cntw    : width of a counter that runs 0 .. nd-1 (at least 1 bit)
package monty_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } wsmul_state_t;

    function automatic int wsmul_nd(input int logq, input int dw);
        return logq / dw;
    endfunction

    function automatic int wsmul_lat(input int logq, input int dw);
        return wsmul_nd(logq, dw) + 1;
    endfunction

    function automatic int wsmul_cntw(input int nd);
        return (nd > 1) ? $clog2(nd) : 1;
    endfunction

endpackage

// File: rtl/wsmul_acc.sv
// One multiply-shift-accumulate step of the word-serial multiplier.
// Combinational: acc_next_o = acc_i + (a_i * digit_i) << (cnt_i * DW).
//   acc_i      : running 2*LOGQ-bit accumulator
//   a_i        : latched multiplicand
//   digit_i    : current DW-bit digit of B
//   cnt_i      : index of that digit (selects the shift)
//   acc_next_o : updated accumulator
module wsmul_acc
    import monty_pkg::*;
#(
    parameter int LOGQ = 32,
    parameter int DW   = 8
) (
    input  logic [2*LOGQ-1:0]                         acc_i,
    input  logic [LOGQ-1:0]                           a_i,
    input  logic [DW-1:0]                             digit_i,
    input  logic [wsmul_cntw(wsmul_nd(LOGQ, DW))-1:0] cnt_i,
    output logic [2*LOGQ-1:0]                         acc_next_o
);

    logic [LOGQ+DW-1:0] pp;
    logic [2*LOGQ-1:0]  pp_shifted;
    logic [31:0]        shamt;

    always_comb begin
        // Partial product is LOGQ+DW bits; positioned at digit weight it
        // still fits in 2*LOGQ, so the sum can never overflow.
        pp         = {{DW{1'b0}}, a_i} * {{LOGQ{1'b0}}, digit_i};
        shamt      = 32'(cnt_i) * 32'(DW);
        pp_shifted = (2*LOGQ)'(pp) << shamt;
        acc_next_o = acc_i + pp_shifted;
    end

endmodule

// File: rtl/wsmul.sv
// Word-serial integer multiplier: C = A * B, consuming one DW-bit digit of B
// per cycle (LSB digit first). qH is captured with the operands and
// presented next to C so the downstream reducer gets a matched pair.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake for {A, B, qH_in}
//   A, B                 : LOGQ-bit operands
//   qH_in                : LOGQH-bit modulus high part (pass-through)
//   out_valid / out_ready: result handshake for {C, qH_out}
//   C                    : 2*LOGQ-bit product
//   qH_out               : qH captured at accept
//   busy                 : high while digits are being processed
module wsmul
    import monty_pkg::*;
#(
    parameter int LOGQ  = 32,
    parameter int LOGQH = 19,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LOGQ-1:0]   A,
    input  logic [LOGQ-1:0]   B,
    input  logic [LOGQH-1:0]  qH_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*LOGQ-1:0] C,
    output logic [LOGQH-1:0]  qH_out,
    output logic              busy
);

    localparam int ND = wsmul_nd(LOGQ, DW);
    localparam int CW = wsmul_cntw(ND);

    generate
        if (LOGQ % DW != 0) begin : g_dw_check
            $error("wsmul: LOGQ must be a multiple of DW");
        end
    endgenerate

    wsmul_state_t      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LOGQ-1:0]   a_q, a_d;
    logic [LOGQ-1:0]   b_q, b_d;
    logic [2*LOGQ-1:0] acc_q, acc_d;
    logic [2*LOGQ-1:0] c_q, c_d;
    logic [LOGQH-1:0]  qh_q, qh_d;
    logic [2*LOGQ-1:0] acc_next;
    logic              accept;

    // B is shifted right each BUSY cycle, so the current digit is always
    // the low DW bits; cnt_q only sets the weight of the partial product.
    wsmul_acc #(
        .LOGQ (LOGQ),
        .DW   (DW)
    ) u_acc (
        .acc_i      (acc_q),
        .a_i        (a_q),
        .digit_i    (b_q[DW-1:0]),
        .cnt_i      (cnt_q),
        .acc_next_o (acc_next)
    );

    // in_ready is masked by rst so nothing is accepted during reset.
    assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign C         = c_q;
    assign qH_out    = qh_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        qh_d    = qh_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    qh_d    = qH_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_next;
                b_d   = b_q >> DW;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ND - 1)) begin
                    c_d     = acc_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            qh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            qh_q    <= qh_d;
        end
    end

endmodule

// File: tb/tb_wsmul.sv
// Directed bench for wsmul: one instance with DW=8 (4 digits) and one with
// DW=4 (8 digits). A per-instance monitor keeps a queue of expected
// products (reference A*B taken at each input handshake) and checks every
// output handshake, latency, pairing of qH and absence of spurious outputs.
module tb_wsmul;

    logic        clk;
    logic        rst;

    logic        iv8, ir8, ov8, or8, busy8;
    logic [31:0] a8, b8;
    logic [18:0] qhi8, qho8;
    logic [63:0] c8;

    logic        iv4, ir4, ov4, or4, busy4;
    logic [31:0] a4, b4;
    logic [18:0] qhi4, qho4;
    logic [63:0] c4;

    int n_checks = 0;
    int n_errors = 0;

    wsmul #(.LOGQ(32), .LOGQH(19), .DW(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .qH_in(qhi8), .out_valid(ov8), .out_ready(or8), .C(c8), .qH_out(qho8),
        .busy(busy8)
    );

    wsmul #(.LOGQ(32), .LOGQH(19), .DW(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .qH_in(qhi4), .out_valid(ov4), .out_ready(or4), .C(c4), .qH_out(qho4),
        .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitors / scoreboards ----------------
    logic [63:0] q_c8[$];
    logic [18:0] q_q8[$];
    int          q_t8[$];
    logic [63:0] q_c4[$];
    logic [18:0] q_q4[$];
    int          q_t4[$];
    int          hs8 = 0, hs4 = 0;
    bit          b2b = 0;
    int          b2b_n = 0;

    initial begin
        int  ncyc = 0;
        bit  seen = 0;
        int  last_hs = 0;
        forever begin
            @(negedge clk);
            #1;
            ncyc++;
            if (rst) begin
                q_c8.delete(); q_q8.delete(); q_t8.delete();
                seen = 0;
            end else begin
                if (ov8) begin
                    if (!seen) begin
                        seen = 1;
                        if (q_t8.size() > 0) check("lat8", ncyc - q_t8[0], 5);
                        else check("spurious8", ov8, 1'b0);
                    end
                    if (or8) begin
                        $display("dut8 result C=0x%016h qH=0x%05h", c8, qho8);
                        if (q_c8.size() > 0) begin
                            check("c8", c8, q_c8[0]);
                            check("qh8", qho8, q_q8[0]);
                            void'(q_c8.pop_front()); void'(q_q8.pop_front()); void'(q_t8.pop_front());
                        end else begin
                            check("dup8", ov8, 1'b0);
                        end
                        if (b2b) begin
                            if (b2b_n > 0) check("gap8", ncyc - last_hs, 5);
                            b2b_n++;
                        end
                        last_hs = ncyc;
                        hs8++;
                        seen = 0;
                    end
                end
                if (iv8 && ir8) begin
                    q_c8.push_back(64'(a8) * 64'(b8));
                    q_q8.push_back(qhi8);
                    q_t8.push_back(ncyc);
                end
            end
        end
    end

    initial begin
        int ncyc = 0;
        bit seen = 0;
        forever begin
            @(negedge clk);
            #1;
            ncyc++;
            if (rst) begin
                q_c4.delete(); q_q4.delete(); q_t4.delete();
                seen = 0;
            end else begin
                if (ov4) begin
                    if (!seen) begin
                        seen = 1;
                        if (q_t4.size() > 0) check("lat4", ncyc - q_t4[0], 9);
                        else check("spurious4", ov4, 1'b0);
                    end
                    if (or4) begin
                        $display("dut4 result C=0x%016h qH=0x%05h", c4, qho4);
                        if (q_c4.size() > 0) begin
                            check("c4", c4, q_c4[0]);
                            check("qh4", qho4, q_q4[0]);
                            void'(q_c4.pop_front()); void'(q_q4.pop_front()); void'(q_t4.pop_front());
                        end else begin
                            check("dup4", ov4, 1'b0);
                        end
                        hs4++;
                        seen = 0;
                    end
                end
                if (iv4 && ir4) begin
                    q_c4.push_back(64'(a4) * 64'(b4));
                    q_q4.push_back(qhi4);
                    q_t4.push_back(ncyc);
                end
            end
        end
    end

    bit rand_or4 = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_or4) or4 = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic drive8(input logic [31:0] a, input logic [31:0] b, input logic [18:0] q);
        int g = 0;
        a8 = a; b8 = b; qhi8 = q; iv8 = 1'b1;
        while (!ir8 && g < 100) begin @(negedge clk); g++; end
        if (!ir8) check("accept_timeout8", ir8, 1'b1);
        @(negedge clk);
    endtask

    task automatic drive4(input logic [31:0] a, input logic [31:0] b, input logic [18:0] q);
        int g = 0;
        a4 = a; b4 = b; qhi4 = q; iv4 = 1'b1;
        while (!ir4 && g < 500) begin @(negedge clk); g++; end
        if (!ir4) check("accept_timeout4", ir4, 1'b1);
        @(negedge clk);
    endtask

    task automatic run8(input logic [31:0] a, input logic [31:0] b, input logic [18:0] q,
                        input logic [63:0] exp_c, input string tag);
        int n = 0;
        drive8(a, b, q);
        iv8 = 1'b0;
        while (!ov8 && n < 200) begin @(negedge clk); n++; end
        check({tag, "_lat"}, n, 4);
        check({tag, "_c"}, c8, exp_c);
        check({tag, "_qh"}, qho8, q);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        rst = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; qhi8 = 0; or8 = 1;
        iv4 = 0; a4 = 0; b4 = 0; qhi4 = 0; or4 = 1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", ov8, 1'b0);
        check("rst_c", c8, 64'd0);
        check("rst_qh", qho8, 19'd0);
        check("rst_in_ready", ir8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", ir8, 1'b1);

        // 1: max operands, busy for 4 cycles then result with in_ready high
        drive8(32'hFFFF_FFFF, 32'hFFFF_FFFF, 19'h7FFFF);
        iv8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_busy", busy8, 1'b1);
            check("t1_no_valid", ov8, 1'b0);
            @(negedge clk);
        end
        check("t1_valid", ov8, 1'b1);
        check("t1_c", c8, 64'hFFFF_FFFE_0000_0001);
        check("t1_qh", qho8, 19'h7FFFF);
        check("t1_in_ready", ir8, 1'b1);
        @(negedge clk);
        check("t1_idle", ov8, 1'b0);

        // 2: zero multiplicand and single high bit
        run8(32'h0000_0000, 32'h1234_5678, 19'h00001, 64'h0, "t2a");
        run8(32'h0000_0001, 32'h8000_0000, 19'h12345, 64'h0000_0000_8000_0000, "t2b");
        @(negedge clk);

        // 3: backpressure holds the result
        or8 = 1'b0;
        run8(32'd3, 32'd5, 19'h00ABC, 64'd15, "t3");
        a8 = 32'd1; b8 = 32'd1; iv8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", ov8, 1'b1);
            check("t3_hold_c", c8, 64'd15);
            check("t3_hold_in_ready", ir8, 1'b0);
            @(negedge clk);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        check("t3_released", ov8, 1'b0);
        check("t3_idle_busy", busy8, 1'b0);
        check("t3_idle_ready", ir8, 1'b1);

        // 4: back-to-back stream
        b2b_n = 0;
        b2b = 1;
        for (int i = 0; i < 8; i++) drive8($urandom, $urandom, 19'($urandom));
        iv8 = 1'b0;
        g = 0;
        while (q_c8.size() != 0 && g < 100) begin @(negedge clk); g++; end
        @(negedge clk);
        b2b = 0;
        check("t4_count", b2b_n, 8);

        // 5: asynchronous reset in the middle of BUSY
        drive8(32'd7, 32'd9, 19'h00777);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_out_valid", ov8, 1'b0);
        check("t5_c", c8, 64'd0);
        check("t5_in_ready", ir8, 1'b0);
        check("t5_busy", busy8, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t5_no_stale", ov8, 1'b0);
            @(negedge clk);
        end
        run8(32'd2, 32'd3, 19'h00123, 64'd6, "t5");
        @(negedge clk);
        check("t5_drained", q_c8.size(), 0);

        // 6: DW=4 instance, random vectors with random out_ready
        rand_or4 = 1;
        for (int i = 0; i < 1000; i++) begin
            int gap;
            drive4($urandom, $urandom, 19'($urandom));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                iv4 = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        iv4 = 1'b0;
        g = 0;
        while (q_c4.size() != 0 && g < 300) begin @(negedge clk); g++; end
        rand_or4 = 0;
        or4 = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_drained", q_c4.size(), 0);
        check("t6_handshakes", hs4, 1000);
        check("t6_no_extra", ov4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wsmul.md
Name: wsmul

Overview:
- Word-serial integer multiplier that sits directly upstream of the word-level Montgomery reducer.
- Accepts operands A and B, each LOGQ bits, and produces the full 2*LOGQ-bit product C = A*B by consuming one DW-bit digit of B per cycle.
- Forwards the modulus high part qH alongside C, so the reducer receives a matched {qH, C} pair.
- Intended for area-constrained datapaths where a full-width LOGQ x LOGQ multiplier is too costly.
- Uses valid/ready handshakes on both sides.

Parameters:
- LOGQ, 32, operand width in bits; C is 2*LOGQ bits.
- LOGQH, 19, width of qH (modulus q = qH*2^(LOGQ-LOGQH) + 1); qH is passed through only.
- DW, 8, B digit width consumed per cycle; LOGQ % DW == 0 is required (elaboration-time assertion); ND = LOGQ/DW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set {A, B, qH_in} is valid.
- in_ready  out  1  block can accept an operand set.
- A  in  LOGQ  multiplicand.
- B  in  LOGQ  multiplier, consumed LSB digit first.
- qH_in  in  LOGQH  modulus high part captured with the operands.
- out_valid  out  1  C and qH_out are valid.
- out_ready  in  1  downstream (reducer) accepts the result.
- C  out  2*LOGQ  product A*B, fed to the reducer's C input.
- qH_out  out  LOGQH  qH captured at accept, fed to the reducer's qH input.
- busy  out  1  high while in BUSY state.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; out_valid = 0; C = 0; qH_out = 0; digit counter = 0; internal A/B/accumulator registers = 0.
  - in_ready is forced to 0 while rst is high.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch A, B and qH_in, clear the accumulator and counter, and go to BUSY.
  - BUSY: in_ready = 0; busy = 1. Each cycle: acc += A * B[cnt*DW +: DW] << (cnt*DW), then cnt++. A right-shifting accumulator equivalent is allowed if the result is identical. After ND cycles (cnt == ND-1 processed), load C = acc and go to DONE.
  - DONE: out_valid = 1; C and qH_out are held stable.
    - On out_valid & out_ready, go to IDLE.
    - If in_valid is also high in the same cycle, accept the new operands and go directly to BUSY.
    - Hence in_ready = IDLE | (DONE & out_ready).
- Latency: operands accepted at edge t → out_valid rises after edge t+ND. Throughput is one product per ND+1 cycles when out_ready = 1.
- Backpressure: with out_ready = 0 in DONE, C, qH_out and out_valid are held indefinitely and no new input is accepted.
- Width rules:
  - The accumulator is 2*LOGQ bits and never overflows, since (2^LOGQ-1)^2 < 2^(2*LOGQ).
  - Each partial product is LOGQ+DW bits.
- in_valid in BUSY is ignored. Operands must be held by the source until in_ready; they are not sampled otherwise.
- Reset mid-operation aborts the operation with no output; the next accept after reset starts fresh.
- out_valid never rises without a prior accept. Exactly one output handshake occurs per input handshake.
- C depends only on the latched values; changes to A/B/qH_in after accept have no effect.

Decomposition:
- Shared package monty_pkg:
  - wsmul_state_t enum {IDLE, BUSY, DONE}.
  - function wsmul_nd(LOGQ, DW) = LOGQ/DW.
  - function wsmul_lat(LOGQ, DW) = wsmul_nd + 1, so top-level latency budgets can be composed with the reducer latency functions.
- Sub-module wsmul_acc: combinational DW x LOGQ digit multiply, shift and accumulate step (inputs acc, A, digit, cnt; output acc_next). The FSM, counter and registers stay in wsmul.

Test Plan:
1. LOGQ=32, DW=8: A=0xFFFFFFFF, B=0xFFFFFFFF, qH_in=0x7FFFF, out_ready=1 → after accept, busy for 4 cycles, then out_valid=1 with C=0xFFFFFFFE00000001 and qH_out=0x7FFFF; in_ready=1 the same cycle.
2. A=0x00000000, B=0x12345678 → C=0. Then A=0x00000001, B=0x80000000 → C=0x0000000080000000; in both cases out_valid appears exactly 4 cycles after accept.
3. Backpressure: A=3, B=5, out_ready=0 for 10 cycles → C=15 held stable, out_valid=1 and in_ready=0 throughout. out_ready=1 → one handshake, then IDLE.
4. Back-to-back: in_valid held high with a stream of 8 random operand sets, out_ready=1 → one result every 5 cycles; every C matches a reference A*B and qH_out is paired correctly.
5. Reset mid-BUSY: accept A=7, B=9, assert rst asynchronously after 2 BUSY cycles → out_valid=0, C=0 and in_ready=0 immediately. After release, no stale output appears and the next operation A=2, B=3 yields C=6.
6. LOGQ=32, DW=4, 1000 random vectors with random out_ready → all C correct, latency 8 cycles from accept to out_valid, no handshake lost or duplicated.
